// File: rtl/igniter_sequencer.sv
// Jump sequencer for the igniter: replays a host-loaded table of signed deltas
// with a programmable dwell between jumps and tracks the expected igniter position.
module igniter_sequencer #(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned DWELL_W = 8
) (
   input  logic               sys_clk,
   input  logic               clr_n,
   input  logic               wr_en,
   input  logic [2:0]         wr_addr,
   input  logic [3:0]         wr_delta,
   input  logic [3:0]         seq_len,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               start,
   input  logic               abort,
   output logic [3:0]         delta,
   output logic               enable_jump,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [2:0]         step_idx,
   output logic [2:0]         exp_position
);

   localparam int unsigned DW = 4;
   localparam int unsigned LW = 4;
   localparam int unsigned AW = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DWELL = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [DW-1:0]        table_q [DEPTH];
   logic [DW-1:0]        table_d [DEPTH];
   logic [LW-1:0]        len_q, len_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]        step_idx_q, step_idx_d;
   logic [AW-1:0]        exp_position_q, exp_position_d;
   logic [DW-1:0]        delta_q, delta_d;
   logic                 enable_jump_q, enable_jump_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 aborted_q, aborted_d;
   logic [LW-1:0]        req_len_c;
   logic                 last_c;

   // Requested length clamped to the table depth.
   assign req_len_c = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;
   assign last_c    = ({1'b0, step_idx_q} == (len_q - LW'(1)));

   always_ff @(posedge sys_clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q        <= S_IDLE;
         for (int i = 0; i < int'(DEPTH); i++) table_q[i] <= '0;
         len_q          <= '0;
         dwell_q        <= '0;
         cnt_q          <= '0;
         step_idx_q     <= '0;
         exp_position_q <= '0;
         delta_q        <= '0;
         enable_jump_q  <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         aborted_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         table_q        <= table_d;
         len_q          <= len_d;
         dwell_q        <= dwell_d;
         cnt_q          <= cnt_d;
         step_idx_q     <= step_idx_d;
         exp_position_q <= exp_position_d;
         delta_q        <= delta_d;
         enable_jump_q  <= enable_jump_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         aborted_q      <= aborted_d;
      end
   end

   // Next state plus registered outputs derived from the state being entered.
   always_comb begin
      state_d        = state_q;
      table_d        = table_q;
      len_d          = len_q;
      dwell_d        = dwell_q;
      cnt_d          = cnt_q;
      step_idx_d     = step_idx_q;
      aborted_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (wr_en && (32'(wr_addr) < DEPTH)) table_d[wr_addr] = wr_delta;
            if (start && !abort) begin
               len_d      = req_len_c;
               dwell_d    = dwell;
               step_idx_d = '0;
               state_d    = (req_len_c != '0) ? S_ISSUE : S_DONE;
            end
         end
         S_ISSUE: begin
            if (abort) begin
               state_d   = S_IDLE;
               aborted_d = 1'b1;
            end else if (dwell_q != '0) begin
               state_d = S_DWELL;
               cnt_d   = dwell_q;
            end else if (last_c) begin
               state_d = S_DONE;
            end else begin
               step_idx_d = step_idx_q + AW'(1);
               state_d    = S_ISSUE;
            end
         end
         S_DWELL: begin
            if (abort) begin
               state_d   = S_IDLE;
               aborted_d = 1'b1;
            end else if (cnt_q == DWELL_W'(1)) begin
               if (last_c) begin
                  state_d = S_DONE;
               end else begin
                  step_idx_d = step_idx_q + AW'(1);
                  state_d    = S_ISSUE;
               end
            end else begin
               cnt_d = cnt_q - DWELL_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      enable_jump_d  = (state_d == S_ISSUE);
      delta_d        = enable_jump_d ? table_q[step_idx_d] : '0;
      exp_position_d = exp_position_q + (enable_jump_d ? delta_d[AW-1:0] : AW'(0));
      busy_d         = (state_d != S_IDLE);
      done_d         = (state_d == S_DONE);
   end

   assign delta        = delta_q;
   assign enable_jump  = enable_jump_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign aborted      = aborted_q;
   assign step_idx     = step_idx_q;
   assign exp_position = exp_position_q;

endmodule

// File: tb/tb_igniter_sequencer.sv
// Directed bench for igniter_sequencer; expected values are hand-derived per step.
module tb_igniter_sequencer;

   logic       sys_clk = 1'b0;
   logic       clr_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [3:0] wr_delta = '0;
   logic [3:0] seq_len = '0;
   logic [7:0] dwell = '0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] delta;
   logic       enable_jump, busy, done, aborted;
   logic [2:0] step_idx, exp_position;

   int checks = 0;
   int errors = 0;

   igniter_sequencer dut (
      .sys_clk(sys_clk), .clr_n(clr_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_delta(wr_delta), .seq_len(seq_len), .dwell(dwell), .start(start),
      .abort(abort), .delta(delta), .enable_jump(enable_jump), .busy(busy),
      .done(done), .aborted(aborted), .step_idx(step_idx), .exp_position(exp_position)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input logic [2:0] a, input logic [3:0] d);
      wr_en = 1'b1; wr_addr = a; wr_delta = d;
      step();
      wr_en = 1'b0;
   endtask

   // Leaves the bench in the cycle right after the edge that sampled start.
   task automatic go(input logic [3:0] len, input logic [7:0] dw);
      seq_len = len; dwell = dw; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic jump(input string tag, input logic [3:0] d, input logic [2:0] idx,
                       input logic [2:0] pos);
      chk({tag, "_en"}, 32'(enable_jump), 32'd1);
      chk({tag, "_delta"}, 32'(delta), 32'(d));
      chk({tag, "_idx"}, 32'(step_idx), 32'(idx));
      chk({tag, "_pos"}, 32'(exp_position), 32'(pos));
   endtask

   logic [2:0] wrap_pos [4];
   int         jumps;

   initial begin
      wrap_pos[0] = 3'd7; wrap_pos[1] = 3'd6; wrap_pos[2] = 3'd5; wrap_pos[3] = 3'd2;

      // reset state
      steps(2);
      chk("rst_en", 32'(enable_jump), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_delta", 32'(delta), 32'd0);
      chk("rst_pos", 32'(exp_position), 32'd0);
      clr_n = 1'b1;
      step();

      // basic run: 2, 3, -1 with dwell 2
      wr(3'd0, 4'b0010); wr(3'd1, 4'b0011); wr(3'd2, 4'b1111);
      go(4'd3, 8'd2);
      jump("b0", 4'b0010, 3'd0, 3'd2);
      chk("b0_busy", 32'(busy), 32'd1);
      step(); chk("b_dw1_en", 32'(enable_jump), 32'd0); chk("b_dw1_delta", 32'(delta), 32'd0);
      step(); chk("b_dw2_en", 32'(enable_jump), 32'd0);
      step(); jump("b1", 4'b0011, 3'd1, 3'd5);
      steps(2); chk("b_dw_done", 32'(done), 32'd0);
      step(); jump("b2", 4'b1111, 3'd2, 3'd4);
      steps(2); chk("b_pre_done", 32'(done), 32'd0);
      step(); chk("b_done", 32'(done), 32'd1); chk("b_done_busy", 32'(busy), 32'd1);
      chk("b_done_en", 32'(enable_jump), 32'd0);
      step(); chk("b_idle_busy", 32'(busy), 32'd0); chk("b_idle_done", 32'(done), 32'd0);
      chk("b_idle_pos", 32'(exp_position), 32'd4); chk("b_idle_idx", 32'(step_idx), 32'd2);

      // back-to-back with wrap from a fresh reset
      clr_n = 1'b0; #2; clr_n = 1'b1; step();
      wr(3'd0, 4'd7); wr(3'd1, 4'd7); wr(3'd2, 4'd7); wr(3'd3, 4'b1101);
      go(4'd4, 8'd0);
      for (int i = 0; i < 4; i++) begin
         jump($sformatf("w%0d", i), (i == 3) ? 4'b1101 : 4'd7, 3'(i), wrap_pos[i]);
         step();
      end
      chk("w_done", 32'(done), 32'd1); chk("w_done_en", 32'(enable_jump), 32'd0);
      step(); chk("w_idle_busy", 32'(busy), 32'd0);

      // seq_len above DEPTH clamps to 8 jumps: 2 + 7+7+7+5 = 28 -> 4
      go(4'd12, 8'd0);
      jumps = 0;
      for (int i = 0; i < 8; i++) begin
         if (enable_jump === 1'b1) jumps++;
         step();
      end
      chk("c_jumps", 32'(jumps), 32'd8);
      chk("c_done", 32'(done), 32'd1); chk("c_en", 32'(enable_jump), 32'd0);
      chk("c_idx", 32'(step_idx), 32'd7); chk("c_pos", 32'(exp_position), 32'd4);
      step(); chk("c_idle", 32'(busy), 32'd0);

      // zero length: done at once, no jump
      go(4'd0, 8'd3);
      chk("z_done", 32'(done), 32'd1); chk("z_en", 32'(enable_jump), 32'd0);
      chk("z_busy", 32'(busy), 32'd1);
      step(); chk("z_done2", 32'(done), 32'd0); chk("z_busy2", 32'(busy), 32'd0);
      chk("z_pos", 32'(exp_position), 32'd4);

      // abort in the first dwell: one jump kept (4+7 -> 3)
      go(4'd3, 8'd5);
      jump("a0", 4'd7, 3'd0, 3'd3);
      step(); chk("a_dwell_en", 32'(enable_jump), 32'd0);
      abort = 1'b1;
      step(); abort = 1'b0;
      chk("a_aborted", 32'(aborted), 32'd1); chk("a_busy", 32'(busy), 32'd0);
      chk("a_done", 32'(done), 32'd0);
      step(); chk("a_aborted2", 32'(aborted), 32'd0);
      jumps = 0;
      for (int i = 0; i < 8; i++) begin
         if (enable_jump !== 1'b0 || done !== 1'b0) jumps++;
         step();
      end
      chk("a_quiet", 32'(jumps), 32'd0); chk("a_pos", 32'(exp_position), 32'd3);

      // writes and start while busy are ignored
      go(4'd2, 8'd3);
      jump("p0", 4'd7, 3'd0, 3'd2);
      wr_en = 1'b1; wr_addr = 3'd0; wr_delta = 4'd1; start = 1'b1; seq_len = 4'd1; dwell = 8'd0;
      step();
      wr_en = 1'b0; start = 1'b0;
      chk("p_busy", 32'(busy), 32'd1); chk("p_idx0", 32'(step_idx), 32'd0);
      steps(3); jump("p1", 4'd7, 3'd1, 3'd1);
      steps(4); chk("p_done", 32'(done), 32'd1);
      step();
      go(4'd1, 8'd0);
      jump("p_tbl", 4'd7, 3'd0, 3'd0);
      steps(2); chk("p_idle", 32'(busy), 32'd0);

      // start together with abort in IDLE
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      chk("sa_busy", 32'(busy), 32'd0); chk("sa_en", 32'(enable_jump), 32'd0);
      chk("sa_aborted", 32'(aborted), 32'd0);

      // asynchronous reset mid-sequence
      go(4'd4, 8'd0);
      chk("r_pre_en", 32'(enable_jump), 32'd1);
      #2 clr_n = 1'b0;
      #1;
      chk("r_en", 32'(enable_jump), 32'd0); chk("r_busy", 32'(busy), 32'd0);
      chk("r_delta", 32'(delta), 32'd0); chk("r_done", 32'(done), 32'd0);
      chk("r_idx", 32'(step_idx), 32'd0); chk("r_pos", 32'(exp_position), 32'd0);
      #1 clr_n = 1'b1;
      step();
      go(4'd1, 8'd0);
      jump("r_tbl", 4'd0, 3'd0, 3'd0);
      steps(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
